maj_net_sequencer: RTL and testbench
====================================

MAJ_NET_SEQUENCER -- requirements
Module: maj_net_sequencer

Interface
REQ-001 SHALL have parameter NODES, default 8, giving the number of majority nodes in the program store (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port cfg_we, input, 1, program-store write strobe.
REQ-005 SHALL have port cfg_addr, input, log2(NODES), index of the node written.
REQ-006 SHALL have port cfg_data, input, 3x(1+5), the node's three operands, each {inv, sel[4:0]}.
REQ-007 SHALL have port cfg_last, input, log2(NODES), index of the output node; it is sampled when cfg_we is high.
REQ-008 SHALL have port in_valid, input, 1, an input vector is offered.
REQ-009 SHALL have port in_ready, output, 1, the block accepts the offered vector.
REQ-010 SHALL have port x, input, 7, input vector x0..x6.
REQ-011 SHALL have port out_valid, output, 1, the result is valid.
REQ-012 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-013 SHALL have port out, output, 1, value of node cfg_last.

Function
REQ-014 Operand select encoding SHALL be: 0..6 = x0..x6; 7 = constant 0; 8..8+NODES-1 = node w(sel-8); any other value = constant 0.
REQ-015 Each operand SHALL be XORed with its inv bit before the 3-input majority, so inv on sel 7 gives constant 1.
REQ-016 The FSM SHALL have three states: IDLE -> EVAL on in_valid&&in_ready; EVAL -> DONE after node last_idx is evaluated; DONE -> IDLE on out_valid&&out_ready.
REQ-017 in_ready SHALL be high only in IDLE; x SHALL be registered on acceptance.
REQ-018 EVAL SHALL evaluate exactly one node per cycle, in index order 0..last_idx, and store each result in a node-value register.
REQ-019 A node operand that references a node index >= the current index SHALL read 0, including self-references and stale values from a previous vector.
REQ-020 Latency SHALL be last_idx+2 cycles from acceptance to out_valid (last_idx=0 gives 2).
REQ-021 out_valid and out SHALL hold stable in DONE until out_ready; a result not accepted SHALL block new inputs.
REQ-022 cfg_we SHALL take effect only in IDLE; cfg_we in EVAL or DONE SHALL be ignored and SHALL NOT corrupt the evaluation in progress.
REQ-023 cfg_we and in_valid in the same IDLE cycle SHALL apply the write first, so the accepted vector uses the new program.
REQ-024 The node-value registers SHALL be cleared to 0 on every acceptance.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, in_ready=0 during the reset cycle then 1, out_valid=0, out=0, last_idx=0, node values=0.
REQ-026 Every program-store entry SHALL reset to {0,0},{0,0},{0,0} (maj(x0,x0,x0)=x0).
REQ-027 Reset asserted mid-EVAL or in DONE SHALL abandon the operation; no out_valid pulse SHALL follow.

Configuration
REQ-028 With MAJ_SEQ_EVALCNT_EN defined, the block SHALL add output eval_count[15:0], reset 0, which increments on each out_valid&&out_ready and saturates at 16'hFFFF.
REQ-029 Without MAJ_SEQ_EVALCNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package maj_seq_pkg SHALL hold: the operand typedef {inv, sel}, the node typedef (3 operands), the select constants (X_BASE=0, CONST0=7, NODE_BASE=8) and the FSM state enum.
REQ-031 Sub-module maj3 SHALL be the single combinational 3-input majority cell, with operand muxing and inversion kept outside it.

Verification
REQ-032 Program node0=maj(x1,x2,x3), last=0; x=7'b0000110 -> out=1 after 2 cycles; x=7'b0000010 -> out=0.
REQ-033 Program a 5-node two-level network, last=4; sweep all 128 x vectors against a software majority model -> every out matches, latency 6.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out stable, in_ready=0, and a concurrent in_valid is not accepted.
REQ-035 Pulse cfg_we with a program that inverts the output during EVAL -> the current result and the next result are unchanged.
REQ-036 Node1 operand set to node1 or node3 -> the operand reads 0; sel=7 with inv=1 -> reads 1.
REQ-037 Assert rst_n=0 in the 2nd EVAL cycle -> no out_valid, in_ready=1 one cycle after release; with MAJ_SEQ_EVALCNT_EN, 70000 handshakes -> eval_count=16'hFFFF.

Source files
------------

// File: rtl/maj_seq_pkg.sv
// maj_seq_pkg: shared types and select constants for the majority-network sequencer.
// Operand = {inv, sel}; node = three operands; FSM state encoding.
package maj_seq_pkg;

   typedef struct packed {
      logic       inv;
      logic [4:0] sel;
   } opnd_t;

   typedef struct packed {
      opnd_t c;
      opnd_t b;
      opnd_t a;
   } node_t;

   localparam logic [4:0] X_BASE    = 5'd0;
   localparam logic [4:0] CONST0    = 5'd7;
   localparam logic [4:0] NODE_BASE = 5'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/maj_net_sequencer_maj3.sv
// maj3: single 3-input majority cell.
// Operand selection and inversion live in the caller.
module maj3 (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic y_o
);

   // majority of three inputs
   always_comb begin
      y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
   end

endmodule

// File: rtl/maj_net_sequencer.sv
// maj_net_sequencer: evaluates a programmable majority network one node per cycle.
// Define MAJ_SEQ_EVALCNT_EN to add the saturating eval_count output.
module maj_net_sequencer
   import maj_seq_pkg::*;
#(
   parameter int NODES = 8,
   localparam int AW = $clog2(NODES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [17:0]   cfg_data,
   input  logic [AW-1:0] cfg_last,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [6:0]    x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out
`ifdef MAJ_SEQ_EVALCNT_EN
   ,
   output logic [15:0]   eval_count
`endif
);

   state_t          state_q;
   node_t           prog_q [NODES];
   logic [AW-1:0]   last_q;
   logic [AW-1:0]   idx_q;
   logic [NODES-1:0] nv_q;
   logic [6:0]      x_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            out_q;
   node_t           nd_d;
   logic [2:0]      opv_d;
   logic            res_d;
   logic [4:0]      idx5_d;

   // Operand value: inputs, constant 0, or an already-evaluated node
   function automatic logic opval(
      input opnd_t            o,
      input logic [6:0]       xv,
      input logic [NODES-1:0] nv,
      input logic [4:0]       idx5
   );
      logic       v;
      logic [4:0] xs;
      logic [4:0] ns;
      v  = 1'b0;
      xs = o.sel - X_BASE;
      ns = o.sel - NODE_BASE;
      if (o.sel < CONST0) begin
         v = xv[xs[2:0]];
      end else if (o.sel >= NODE_BASE && ns < idx5) begin
         v = nv[ns[AW-1:0]];
      end
      return v ^ o.inv;
   endfunction

   // Fetch the current node and resolve its three operands
   always_comb begin
      idx5_d   = {{(5-AW){1'b0}}, idx_q};
      nd_d     = prog_q[idx_q];
      opv_d[0] = opval(nd_d.a, x_q, nv_q, idx5_d);
      opv_d[1] = opval(nd_d.b, x_q, nv_q, idx5_d);
      opv_d[2] = opval(nd_d.c, x_q, nv_q, idx5_d);
   end

   maj3 u_maj3 (
      .a_i (opv_d[0]),
      .b_i (opv_d[1]),
      .c_i (opv_d[2]),
      .y_o (res_d)
   );

   // Sequencer FSM: program writes in IDLE, node-per-cycle EVAL, hold in DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= 1'b0;
         last_q      <= '0;
         idx_q       <= '0;
         nv_q        <= '0;
         x_q         <= '0;
         for (int i = 0; i < NODES; i++) begin
            prog_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (cfg_we) begin
                  prog_q[cfg_addr] <= node_t'(cfg_data);
                  last_q           <= cfg_last;
               end
               if (in_valid && in_ready_q) begin
                  x_q        <= x;
                  nv_q       <= '0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= EVAL;
               end
            end
            EVAL: begin
               nv_q[idx_q] <= res_d;
               if (idx_q == last_q) begin
                  out_q       <= res_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;

`ifdef MAJ_SEQ_EVALCNT_EN
   logic [15:0] cnt_q;

   // Count accepted results, saturating at all-ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (out_valid_q && out_ready && cnt_q != 16'hFFFF) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign eval_count = cnt_q;
`endif

endmodule

// File: tb/tb_maj_net_sequencer.sv
// tb_maj_net_sequencer: directed self-checking bench for maj_net_sequencer.
// Covers MAJ_SEQ_EVALCNT_EN when that macro is defined.
module tb_maj_net_sequencer;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [17:0] cfg_data;
   logic [2:0]  cfg_last;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  x;
   logic        out_valid;
   logic        out_ready;
   logic        out;
`ifdef MAJ_SEQ_EVALCNT_EN
   logic [15:0] eval_count;
`endif

   int checks = 0;
   int errors = 0;

   maj_net_sequencer #(.NODES(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_last  (cfg_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
`ifdef MAJ_SEQ_EVALCNT_EN
      ,
      .eval_count(eval_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] op(input logic inv, input logic [4:0] sel);
      return {inv, sel};
   endfunction

   function automatic logic [17:0] nd(input logic [5:0] a,
                                      input logic [5:0] b,
                                      input logic [5:0] c);
      return {c, b, a};
   endfunction

   function automatic logic mj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic net_model(input logic [6:0] v);
      logic n0, n1, n2, n3;
      n0 = mj(v[0], v[1], v[2]);
      n1 = mj(v[3], ~v[4], v[5]);
      n2 = mj(v[6], ~v[1], 1'b1);
      n3 = mj(n0, n1, n2);
      return mj(n3, ~v[5], 1'b0);
   endfunction

   task automatic cfg(input logic [2:0] a, input logic [17:0] d,
                      input logic [2:0] l);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_last = l;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // mode 0: plain, 1: cfg write in acceptance cycle, 2: cfg write in EVAL
   task automatic run(input logic [6:0] xv, input int mode,
                      input logic [2:0] ca, input logic [17:0] cd,
                      input logic [2:0] cl, output logic o, output int lat);
      x = xv; in_valid = 1'b1;
      if (mode == 1) begin
         cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd; cfg_last = cl;
      end
      @(negedge clk);
      in_valid = 1'b0; cfg_we = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         if (mode == 2 && lat == 1) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd; cfg_last = cl;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      cfg_we = 1'b0;
      o = out;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   logic        o;
   logic        held;
   int          lat;
   logic [17:0] n4_bad;

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      cfg_last = '0; in_valid = 1'b0; x = '0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 1'b0);
`ifdef MAJ_SEQ_EVALCNT_EN
      chk("rst_eval_count", eval_count, 16'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1'b1);

      // default program is maj(x0,x0,x0) with last=0
      run(7'b0000001, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("default_x0_1", o, 1'b1);
      chk("default_lat", lat, 2);
      run(7'b1111110, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("default_x0_0", o, 1'b0);

      // node0 = maj(x1,x2,x3)
      cfg(3'd0, nd(op(0, 5'd1), op(0, 5'd2), op(0, 5'd3)), 3'd0);
      run(7'b0000110, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("n0_110_out", o, 1'b1);
      chk("n0_110_lat", lat, 2);
      run(7'b0000010, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("n0_010_out", o, 1'b0);

      // write and accept in the same cycle: new node0 = ~x1
      run(7'b0000010, 1, 3'd0,
          nd(op(1, 5'd1), op(1, 5'd1), op(1, 5'd1)), 3'd0, o, lat);
      chk("cfg_same_cycle", o, 1'b0);
      run(7'b0000000, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("cfg_same_cycle_b", o, 1'b1);

      // constants and out-of-range selects
      cfg(3'd0, nd(op(1, 5'd7), op(1, 5'd7), op(0, 5'd0)), 3'd0);
      run(7'b0000000, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("const1", o, 1'b1);
      cfg(3'd0, nd(op(0, 5'd20), op(0, 5'd31), op(0, 5'd0)), 3'd0);
      run(7'b0000001, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("sel_out_of_range", o, 1'b0);

      // self and forward references read 0, even after a prior vector
      cfg(3'd0, nd(op(1, 5'd7), op(1, 5'd7), op(1, 5'd7)), 3'd3);
      cfg(3'd1, nd(op(0, 5'd9), op(0, 5'd11), op(0, 5'd8)), 3'd3);
      cfg(3'd2, nd(op(1, 5'd7), op(1, 5'd7), op(1, 5'd7)), 3'd3);
      cfg(3'd3, nd(op(0, 5'd10), op(0, 5'd10), op(0, 5'd9)), 3'd3);
      run(7'b0000000, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("fwd_n3", o, 1'b1);
      chk("fwd_lat", lat, 5);
      cfg(3'd1, nd(op(0, 5'd9), op(0, 5'd11), op(0, 5'd8)), 3'd1);
      run(7'b0000000, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("fwd_self_n1", o, 1'b0);

      // five-node two-level network, sweep all inputs
      cfg(3'd0, nd(op(0, 5'd0), op(0, 5'd1), op(0, 5'd2)), 3'd4);
      cfg(3'd1, nd(op(0, 5'd3), op(1, 5'd4), op(0, 5'd5)), 3'd4);
      cfg(3'd2, nd(op(0, 5'd6), op(1, 5'd1), op(1, 5'd7)), 3'd4);
      cfg(3'd3, nd(op(0, 5'd8), op(0, 5'd9), op(0, 5'd10)), 3'd4);
      cfg(3'd4, nd(op(0, 5'd11), op(1, 5'd5), op(0, 5'd7)), 3'd4);
      for (int v = 0; v < 128; v++) begin
         run(7'(v), 0, 3'd0, 18'd0, 3'd0, o, lat);
         chk($sformatf("net_x%0d", v), o, net_model(7'(v)));
         chk($sformatf("net_lat_x%0d", v), lat, 6);
      end

      // a write during EVAL must be ignored now and later
      n4_bad = nd(op(1, 5'd11), op(1, 5'd11), op(1, 5'd11));
      run(7'b0101011, 2, 3'd4, n4_bad, 3'd3, o, lat);
      chk("eval_cfg_cur", o, net_model(7'b0101011));
      chk("eval_cfg_lat", lat, 6);
      run(7'b0101011, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("eval_cfg_next", o, net_model(7'b0101011));
      run(7'b1010100, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("eval_cfg_next_b", o, net_model(7'b1010100));

      // backpressure in DONE with a competing input offer
      x = 7'b0000111; in_valid = 1'b1;
      @(negedge clk);
      x = 7'b1110000;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("hold_lat", lat, 6);
      held = out;
      chk("hold_value", held, net_model(7'b0000111));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("hold_valid_%0d", c), out_valid, 1'b1);
         chk($sformatf("hold_out_%0d", c), out, held);
         chk($sformatf("hold_ready_%0d", c), in_ready, 1'b0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hold_release_valid", out_valid, 1'b0);
      chk("hold_release_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("hold_no_accept", in_ready, 1'b1);

      // reset in the second EVAL cycle abandons the vector
      x = 7'b0000111; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", in_ready, 1'b1);
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("midrst_no_valid_%0d", c), out_valid, 1'b0);
         @(negedge clk);
      end
      run(7'b0000001, 0, 3'd0, 18'd0, 3'd0, o, lat);
      chk("midrst_default_prog", o, 1'b1);
      chk("midrst_default_lat", lat, 2);

`ifdef MAJ_SEQ_EVALCNT_EN
      chk("evalcnt_one", eval_count, 16'd1);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 70000 * 3 + 30; c++) begin
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("evalcnt_sat", eval_count, 16'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
